// File: rtl/out_port_arbiter.sv
// Round-robin sharing of the registered output port between NUM_REQ producers.
// Each granted word is held on out_data for HOLD_CYCLES cycles.
module out_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic [SRC_W-1:0]          out_src,
  output logic                      busy
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [SRC_W:0]     NUM_REQ_W  = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0]   LAST_REQ   = SRC_W'(NUM_REQ-1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES-1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

  state_t                  state;
  logic [CNT_W-1:0]        hold_cnt;
  logic [SRC_W-1:0]        last_grant;

  logic                    arb_cycle;
  logic                    grant_found;
  logic [SRC_W-1:0]        grant_idx;
  logic [DATA_W-1:0]       grant_data;
  logic [2*NUM_REQ-1:0]    rot;
  logic [SRC_W:0]          pos;
  logic                    xfer;

  assign arb_cycle = (state == IDLE) || (hold_cnt == '0);

  // Rotate a doubled request vector so bit 0 is the slot after last_grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    pos         = '0;
    rot = {req_valid, req_valid} >> ({1'b0, last_grant} + 1'b1);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot[k]) begin
        grant_found = 1'b1;
        pos = {1'b0, last_grant} + (SRC_W+1)'(k + 1);
        if (pos >= NUM_REQ_W) begin
          pos = pos - NUM_REQ_W;
        end
        grant_idx = pos[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        grant_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && en && arb_cycle && grant_found) begin
      req_ready = ONE_HOT0 << grant_idx;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= LAST_REQ;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_src    <= '0;
      busy       <= 1'b0;
    end else if (arb_cycle) begin
      if (xfer) begin
        state      <= HOLD;
        hold_cnt   <= HOLD_LAST;
        last_grant <= grant_idx;
        out_data   <= grant_data;
        out_valid  <= 1'b1;
        out_src    <= grant_idx;
        busy       <= 1'b1;
      end else begin
        state      <= IDLE;
        hold_cnt   <= '0;
        out_valid  <= 1'b0;
        busy       <= 1'b0;
      end
    end else begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: a 2-requester/hold-4 instance
// and a 4-requester/hold-1 instance sharing clock, reset and enable.
module tb_out_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;

  logic [1:0]  valid_a;
  logic [15:0] data_a;
  logic [1:0]  ready_a;
  logic [7:0]  odata_a;
  logic        ovalid_a;
  logic [0:0]  osrc_a;
  logic        busy_a;

  logic [3:0]  valid_b;
  logic [31:0] data_b;
  logic [3:0]  ready_b;
  logic [7:0]  odata_b;
  logic        ovalid_b;
  logic [1:0]  osrc_b;
  logic        busy_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  out_port_arbiter #(
    .NUM_REQ(2), .DATA_W(8), .HOLD_CYCLES(4)
  ) u_a (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(valid_a), .req_data(data_a),
    .req_ready(ready_a), .out_data(odata_a),
    .out_valid(ovalid_a), .out_src(osrc_a),
    .busy(busy_a)
  );

  out_port_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(1)
  ) u_b (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .out_data(odata_b),
    .out_valid(ovalid_b), .out_src(osrc_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    valid_a = 2'b11;
    data_a = 16'h0000;
    valid_b = 4'b0000;
    data_b = 32'h0;

    // 1: reset
    cyc();
    cyc();
    chk("rst_ready", 32'(ready_a), 32'h0);
    chk("rst_valid", 32'(ovalid_a), 32'h0);
    chk("rst_data", 32'(odata_a), 32'h00);
    chk("rst_src", 32'(osrc_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_valid_b", 32'(ovalid_b), 32'h0);
    rst = 1'b0;
    valid_a = 2'b00;
    cyc();

    // 2: single word A5 from requester 0
    valid_a = 2'b01;
    data_a = 16'h00A5;
    #1;
    chk("t2_ready", 32'(ready_a), 32'h1);
    cyc();
    valid_a = 2'b00;
    for (int c = 0; c < 4; c++) begin
      chk("t2_data", 32'(odata_a), 32'hA5);
      chk("t2_valid", 32'(ovalid_a), 32'h1);
      chk("t2_src", 32'(osrc_a), 32'h0);
      chk("t2_busy", 32'(busy_a), 32'h1);
      chk("t2_ready_hold", 32'(ready_a), 32'h0);
      cyc();
    end
    chk("t2_valid_end", 32'(ovalid_a), 32'h0);
    chk("t2_data_keep", 32'(odata_a), 32'hA5);
    chk("t2_busy_end", 32'(busy_a), 32'h0);

    // 3: alternating grants, reset first to restore pointer
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    valid_a = 2'b11;
    data_a = 16'h2211;
    #1;
    chk("t3_ready0", 32'(ready_a), 32'h1);
    cyc();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 4; c++) begin
        chk("t3_data", 32'(odata_a),
            (w % 2 == 0) ? 32'h11 : 32'h22);
        chk("t3_src", 32'(osrc_a), 32'(w % 2));
        chk("t3_valid", 32'(ovalid_a), 32'h1);
        chk("t3_ready", 32'(ready_a),
            (c < 3) ? 32'h0 :
            ((w % 2 == 0) ? 32'h2 : 32'h1));
        cyc();
      end
    end
    chk("t3_data5", 32'(odata_a), 32'h11);
    chk("t3_src5", 32'(osrc_a), 32'h0);
    valid_a = 2'b00;
    repeat (4) cyc();
    chk("t3_drain", 32'(ovalid_a), 32'h0);

    // 4: en dropped during hold of 3C (last_grant is 0)
    valid_a = 2'b10;
    data_a = 16'h3C00;
    #1;
    chk("t4_ready", 32'(ready_a), 32'h2);
    cyc();
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t4_data", 32'(odata_a), 32'h3C);
      chk("t4_valid", 32'(ovalid_a), 32'h1);
      chk("t4_src", 32'(osrc_a), 32'h1);
      chk("t4_ready_hold", 32'(ready_a), 32'h0);
      cyc();
    end
    for (int c = 0; c < 2; c++) begin
      chk("t4_valid_off", 32'(ovalid_a), 32'h0);
      chk("t4_ready_off", 32'(ready_a), 32'h0);
      chk("t4_busy_off", 32'(busy_a), 32'h0);
      cyc();
    end
    en = 1'b1;
    #1;
    chk("t4_ready_on", 32'(ready_a), 32'h2);
    cyc();
    chk("t4_regrant", 32'(ovalid_a), 32'h1);
    chk("t4_regrant_d", 32'(odata_a), 32'h3C);
    valid_a = 2'b00;
    repeat (4) cyc();
    chk("t4_drain", 32'(ovalid_a), 32'h0);

    // 5: 4 requesters, hold 1, only requester 2
    valid_b = 4'b0100;
    data_b = 32'h0001_0000;
    #1;
    chk("t5_ready0", 32'(ready_b), 32'h4);
    cyc();
    data_b = 32'h0002_0000;
    #1;
    chk("t5_data1", 32'(odata_b), 32'h01);
    chk("t5_src1", 32'(osrc_b), 32'h2);
    chk("t5_valid1", 32'(ovalid_b), 32'h1);
    chk("t5_ready1", 32'(ready_b), 32'h4);
    cyc();
    data_b = 32'h0003_0000;
    #1;
    chk("t5_data2", 32'(odata_b), 32'h02);
    chk("t5_src2", 32'(osrc_b), 32'h2);
    chk("t5_ready2", 32'(ready_b), 32'h4);
    cyc();
    valid_b = 4'b0000;
    #1;
    chk("t5_data3", 32'(odata_b), 32'h03);
    chk("t5_src3", 32'(osrc_b), 32'h2);
    chk("t5_valid3", 32'(ovalid_b), 32'h1);
    chk("t5_ready3", 32'(ready_b), 32'h0);
    cyc();
    chk("t5_idle", 32'(ovalid_b), 32'h0);
    chk("t5_busy", 32'(busy_b), 32'h0);

    // 6: reset in second hold cycle of 7E from requester 0
    valid_a = 2'b01;
    data_a = 16'h007E;
    #1;
    chk("t6_ready", 32'(ready_a), 32'h1);
    cyc();
    valid_a = 2'b00;
    chk("t6_data", 32'(odata_a), 32'h7E);
    cyc();
    chk("t6_hold2", 32'(odata_a), 32'h7E);
    rst = 1'b1;
    valid_a = 2'b11;
    #1;
    chk("t6_ready_rst", 32'(ready_a), 32'h0);
    cyc();
    rst = 1'b0;
    chk("t6_rdata", 32'(odata_a), 32'h00);
    chk("t6_rvalid", 32'(ovalid_a), 32'h0);
    chk("t6_rsrc", 32'(osrc_a), 32'h0);
    chk("t6_rbusy", 32'(busy_a), 32'h0);
    data_a = 16'h7E55;
    #1;
    chk("t6_ready_ptr", 32'(ready_a), 32'h1);
    cyc();
    chk("t6_gdata", 32'(odata_a), 32'h55);
    chk("t6_gsrc", 32'(osrc_a), 32'h0);
    valid_a = 2'b00;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
